// File: rtl/tile_board_ram.sv
// Multi-port tile-colour board memory with 1-cycle registered reads and a built-in
// sequencer that reloads the whole board from a selectable start layout.
module tile_board_ram #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int DEPTH       = 16,
    parameter int NUM_PORTS   = 3,
    parameter int NUM_LAYOUTS = 2,
    parameter int LSEL_W      = (NUM_LAYOUTS > 1) ? $clog2(NUM_LAYOUTS) : 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          load_req,
    input  logic [LSEL_W-1:0]             load_sel,
    output logic                          busy,
    output logic                          load_done,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    input  logic [NUM_PORTS-1:0]          we,
    output logic [NUM_PORTS*DATA_W-1:0]   rdata,
    output logic                          collision
);

    typedef enum logic {ST_LOAD, ST_IDLE} state_t;

    localparam logic [7:0] L0 [16] = '{
        8'h3C, 8'hC8, 8'hE0, 8'hE0, 8'hD0, 8'h8C, 8'hF0, 8'h0C,
        8'hC8, 8'hD0, 8'hF0, 8'h70, 8'h8C, 8'h70, 8'h3C, 8'h0C
    };

    // Layout k is the base table rotated by 5*k entries; 4-bit truncation gives mod 16.
    function automatic logic [DATA_W-1:0] layout(input logic [LSEL_W-1:0] k,
                                                 input logic [ADDR_W-1:0] i);
        logic [3:0] t;
        t = 4'(32'(i) + 32'd5 * 32'(k));
        return DATA_W'(L0[t]);
    endfunction

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             idx_q, idx_d;
    logic [LSEL_W-1:0]             lsel_q, lsel_d;
    logic                          load_done_q, load_done_d;
    logic [NUM_PORTS*DATA_W-1:0]   rdata_q, rdata_d;
    logic                          collision_q, collision_d;
    logic                          load_we;
    logic [NUM_PORTS-1:0]          port_we;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lsel_d      = lsel_q;
        load_done_d = 1'b0;
        rdata_d     = '0;
        collision_d = 1'b0;
        load_we     = 1'b0;
        port_we     = '0;
        case (state_q)
            ST_LOAD: begin
                load_we = 1'b1;
                idx_d   = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = ST_IDLE;
                    load_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (load_req) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    lsel_d  = (32'(load_sel) < 32'(NUM_LAYOUTS)) ? load_sel : '0;
                end else begin
                    port_we = we;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        rdata_d[p*DATA_W +: DATA_W] = mem[addr[p*ADDR_W +: ADDR_W]];
                        for (int q = p + 1; q < NUM_PORTS; q++) begin
                            if (we[p] && we[q] &&
                                addr[p*ADDR_W +: ADDR_W] == addr[q*ADDR_W +: ADDR_W])
                                collision_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            lsel_q      <= '0;
            load_done_q <= 1'b0;
            rdata_q     <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lsel_q      <= lsel_d;
            load_done_q <= load_done_d;
            rdata_q     <= rdata_d;
            collision_q <= collision_d;
        end
    end

    // Later ports overwrite earlier ones on a shared address, so the highest index wins.
    always_ff @(posedge clk) begin
        if (load_we)
            mem[idx_q] <= layout(lsel_q, idx_q);
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_we[p])
                mem[addr[p*ADDR_W +: ADDR_W]] <= wdata[p*DATA_W +: DATA_W];
        end
    end

    assign busy      = (state_q == ST_LOAD);
    assign load_done = load_done_q;
    assign rdata     = rdata_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_tile_board_ram.sv
// Bench for tile_board_ram: board-level model checked every cycle plus directed
// literal expectations for the reload, read-first, collision and reset scenarios.
module tb_tile_board_ram;
    localparam int DW = 8, AW = 4, DEP = 16, NP = 3, NL = 2, LW = 2;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic              load_req = 1'b0;
    logic [LW-1:0]     load_sel = '0;
    logic              busy, load_done, collision;
    logic [NP*AW-1:0]  addr = '0;
    logic [NP*DW-1:0]  wdata = '0;
    logic [NP-1:0]     we = '0;
    logic [NP*DW-1:0]  rdata;

    int n_checks = 0;
    int n_fail   = 0;
    bit finished = 1'b0;

    tile_board_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NUM_PORTS(NP),
                     .NUM_LAYOUTS(NL), .LSEL_W(LW)) dut (
        .clk(clk), .resetn(resetn), .load_req(load_req), .load_sel(load_sel),
        .busy(busy), .load_done(load_done), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .collision(collision));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- board model ----------------
    int base [16] = '{'h3C, 'hC8, 'hE0, 'hE0, 'hD0, 'h8C, 'hF0, 'h0C,
                      'hC8, 'hD0, 'hF0, 'h70, 'h8C, 'h70, 'h3C, 'h0C};
    int board [DEP];
    int m_rd [NP];
    bit m_loading = 1'b1;
    int m_written = 0;
    int m_sel = 0;
    bit m_done = 1'b0;
    bit m_col = 1'b0;

    function automatic int lay(input int k, input int i);
        return base[(i + 5 * k) % 16];
    endfunction

    always @(posedge clk or posedge resetn) begin
        if (resetn) begin
            m_loading = 1'b1; m_written = 0; m_sel = 0; m_done = 1'b0; m_col = 1'b0;
            for (int p = 0; p < NP; p++) m_rd[p] = 0;
        end else if (m_loading) begin
            board[m_written] = lay(m_sel, m_written);
            m_written++;
            m_col = 1'b0;
            for (int p = 0; p < NP; p++) m_rd[p] = 0;
            m_done = (m_written == DEP);
            if (m_written == DEP) m_loading = 1'b0;
        end else begin
            m_done = 1'b0;
            m_col  = 1'b0;
            if (load_req) begin
                m_loading = 1'b1; m_written = 0;
                m_sel = (int'(load_sel) < NL) ? int'(load_sel) : 0;
                for (int p = 0; p < NP; p++) m_rd[p] = 0;
            end else begin
                int cnt [DEP];
                for (int a = 0; a < DEP; a++) cnt[a] = 0;
                for (int p = 0; p < NP; p++) m_rd[p] = board[addr[p*AW +: AW]];
                for (int p = 0; p < NP; p++)
                    if (we[p]) begin
                        board[addr[p*AW +: AW]] = wdata[p*DW +: DW];
                        cnt[addr[p*AW +: AW]]++;
                    end
                for (int a = 0; a < DEP; a++) if (cnt[a] >= 2) m_col = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!finished) begin
            chk("busy", 32'(busy), 32'(m_loading));
            chk("load_done", 32'(load_done), 32'(m_done));
            chk("collision", 32'(collision), 32'(m_col));
            for (int p = 0; p < NP; p++)
                chk($sformatf("rdata%0d", p), 32'(rdata[p*DW +: DW]), 32'(m_rd[p]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_port(input int p, input int a, input int d, input bit w);
        addr[p*AW +: AW]  = AW'(a);
        wdata[p*DW +: DW] = DW'(d);
        we[p]             = w;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
    endtask

    function automatic logic [31:0] rd(input int p);
        return 32'(rdata[p*DW +: DW]);
    endfunction

    int n;

    initial begin
        // T1: reset, power-on load of layout 0
        repeat (3) step();
        chk("reset_busy", 32'(busy), 1);
        chk("reset_rdata", 32'(rdata), 0);
        resetn = 1'b0;
        wait_idle(n);
        chk("t1_load_len", n, 16);
        chk("t1_load_done", 32'(load_done), 1);
        set_port(0, 0, 0, 0); set_port(2, 15, 0, 0);
        step();
        chk("t1_load_done_drop", 32'(load_done), 0);
        chk("t1_rd0", rd(0), 'h3C);
        chk("t1_rd2", rd(2), 'h0C);

        // T2: read-first against another port's write
        set_port(0, 5, 'hAA, 1); set_port(1, 5, 0, 0);
        step();
        chk("t2_old", rd(1), 'h8C);
        we = '0;
        step();
        chk("t2_new", rd(1), 'hAA);

        // T3: same-address write, highest port wins
        set_port(0, 3, 'h11, 1); set_port(2, 3, 'h22, 1);
        step();
        chk("t3_col", 32'(collision), 1);
        we = '0; set_port(0, 3, 0, 0);
        step();
        chk("t3_col_drop", 32'(collision), 0);
        chk("t3_rd", rd(0), 'h22);

        // mixed traffic patterns checked by the model
        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < NP; p++)
                set_port(p, (i % 2 == 1) ? (p + i) : 7, (i << 4) | p, ((i + 1) >> p) & 1);
            step();
        end
        we = '0;
        for (int a = 0; a < DEP; a += NP) begin
            for (int p = 0; p < NP; p++) set_port(p, (a + p) % DEP, 0, 0);
            step();
        end

        // T4: load accept drops a same-cycle write
        load_req = 1'b1; load_sel = 2'd1; set_port(0, 0, 'h55, 1);
        step();
        load_req = 1'b0; we = '0;
        chk("t4_busy", 32'(busy), 1);
        chk("t4_rd0", rd(0), 0);
        wait_idle(n);
        chk("t4_load_len", n, 16);
        set_port(0, 0, 0, 0); set_port(1, 11, 0, 0);
        step();
        chk("t4_addr0", rd(0), 'h8C);
        chk("t4_addr11", rd(1), 'h3C);

        // T5: reset in the middle of a reload
        load_req = 1'b1; load_sel = 2'd1;
        step();
        load_req = 1'b0;
        repeat (7) step();
        resetn = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 1);
        chk("t5_rdata", 32'(rdata), 0);
        repeat (2) step();
        resetn = 1'b0;
        wait_idle(n);
        chk("t5_load_len", n, 16);
        set_port(0, 4, 0, 0);
        step();
        chk("t5_addr4", rd(0), 'hD0);

        // T6: out-of-range layout select falls back to layout 0
        set_port(1, 1, 'h99, 1);
        step();
        we = '0;
        load_req = 1'b1; load_sel = 2'd3;
        step();
        load_req = 1'b0;
        wait_idle(n);
        chk("t6_load_len", n, 16);
        set_port(1, 1, 0, 0);
        step();
        chk("t6_addr1", rd(1), 'hC8);

        step();
        finished = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
